// File: rtl/placar_registrador_pontos.sv
// Scoreboard front end: synchronises and debounces the A/B/C point buttons and
// applies one signed point event per press to the selected team's stored score.
module placar_registrador_pontos #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MAX_PONTOS      = 99,
  parameter int BUZZ_CYCLES     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       A,
  input  logic       B,
  input  logic       C,
  input  logic       ChaveNegativaPositiva,
  input  logic       MudarTime,
  input  logic       ZerarPlacar,
  output logic [6:0] Placar0,
  output logic [6:0] Placar1,
  output logic       PontoAplicado,
  output logic       Busina
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam int BW = $clog2(BUZZ_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [BW-1:0] BUZZ_INIT = BW'(BUZZ_CYCLES);
  localparam logic [7:0]    MAX8      = 8'(MAX_PONTOS);
  localparam logic [6:0]    MAX7      = 7'(MAX_PONTOS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_APPLY,
    ST_WAIT_RELEASE
  } state_t;

  logic [2:0]    btn_raw;
  logic [2:0]    sync1_q, sync1_d, sync2_q, sync2_d;
  logic [2:0]    deb_q, deb_d, deb_prev_q, deb_prev_d;
  logic [DW-1:0] cnt_q [3];
  logic [DW-1:0] cnt_d [3];
  logic [2:0]    press;
  logic [1:0]    pts_sel;

  state_t        state_q, state_d;
  logic [1:0]    pts_q, pts_d;
  logic          sub_q, sub_d;
  logic          team_q, team_d;
  logic [6:0]    placar0_q, placar0_d, placar1_q, placar1_d;
  logic          pa_q, pa_d;
  logic [BW-1:0] buzz_q, buzz_d;

  logic [6:0]    cur_score;
  logic [7:0]    sum;
  logic [6:0]    new_score;
  logic          illegal;

  assign btn_raw = {C, B, A};

  // Debounce: a level change is accepted only after DEBOUNCE_CYCLES
  // consecutive samples that disagree with the current debounced level.
  always_comb begin
    sync1_d    = btn_raw;
    sync2_d    = sync1_q;
    deb_prev_d = deb_q;
    for (int i = 0; i < 3; i++) begin
      deb_d[i] = deb_q[i];
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DEB_LAST) begin
          deb_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign press = deb_q & ~deb_prev_q;

  always_comb begin
    if (press[2])      pts_sel = 2'd3;
    else if (press[1]) pts_sel = 2'd2;
    else               pts_sel = 2'd1;
  end

  // Score arithmetic for the captured event, evaluated against the stored score.
  always_comb begin
    cur_score = team_q ? placar1_q : placar0_q;
    sum       = {1'b0, cur_score} + {6'b0, pts_q};
    new_score = cur_score;
    illegal   = 1'b0;
    if (!sub_q) begin
      if (sum > MAX8) begin
        new_score = MAX7;
        illegal   = 1'b1;
      end else begin
        new_score = sum[6:0];
      end
    end else if ({5'b0, pts_q} > cur_score) begin
      illegal = 1'b1;
    end else begin
      new_score = cur_score - {5'b0, pts_q};
    end
  end

  always_comb begin
    state_d   = state_q;
    pts_d     = pts_q;
    sub_d     = sub_q;
    team_d    = team_q;
    placar0_d = placar0_q;
    placar1_d = placar1_q;
    pa_d      = 1'b0;
    buzz_d    = (buzz_q != '0) ? buzz_q - 1'b1 : '0;

    case (state_q)
      ST_IDLE: begin
        if (|press) begin
          pts_d   = pts_sel;
          sub_d   = ChaveNegativaPositiva;
          team_d  = MudarTime;
          state_d = ST_APPLY;
        end
      end
      ST_APPLY: begin
        if (team_q) placar1_d = new_score;
        else        placar0_d = new_score;
        pa_d = (new_score != cur_score);
        if (illegal) buzz_d = BUZZ_INIT;
        state_d = ST_WAIT_RELEASE;
      end
      ST_WAIT_RELEASE: begin
        if (deb_q == 3'b000) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Clear beats any pending update; the buzzer keeps running.
    if (ZerarPlacar) begin
      placar0_d = '0;
      placar1_d = '0;
      pa_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
      state_q    <= ST_IDLE;
      pts_q      <= '0;
      sub_q      <= 1'b0;
      team_q     <= 1'b0;
      placar0_q  <= '0;
      placar1_q  <= '0;
      pa_q       <= 1'b0;
      buzz_q     <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
      state_q    <= state_d;
      pts_q      <= pts_d;
      sub_q      <= sub_d;
      team_q     <= team_d;
      placar0_q  <= placar0_d;
      placar1_q  <= placar1_d;
      pa_q       <= pa_d;
      buzz_q     <= buzz_d;
    end
  end

  assign Placar0       = placar0_q;
  assign Placar1       = placar1_q;
  assign PontoAplicado = pa_q;
  assign Busina        = (buzz_q != '0);

endmodule

// File: tb/tb_placar_registrador_pontos.sv
// Bench for placar_registrador_pontos: vector table, hand-timed corner cases
// and random presses checked against an event-level score model.
module tb_placar_registrador_pontos;

  localparam int DEB  = 4;
  localparam int MAXP = 99;
  localparam int BUZZ = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       A, B, C;
  logic       ChaveNegativaPositiva, MudarTime, ZerarPlacar;
  logic [6:0] Placar0, Placar1;
  logic       PontoAplicado, Busina;

  int total = 0;
  int bad   = 0;
  int pa_cnt = 0;
  int bz_cnt = 0;
  int m0 = 0;
  int m1 = 0;

  typedef struct {
    logic [2:0] mask;
    int         hold;
    bit         sub;
    bit         team;
    int         e0;
    int         e1;
    int         epa;
    int         ebz;
  } vec_t;

  vec_t vecs [12];

  placar_registrador_pontos #(
    .DEBOUNCE_CYCLES(DEB),
    .MAX_PONTOS(MAXP),
    .BUZZ_CYCLES(BUZZ)
  ) dut (
    .clk(clk),
    .reset(reset),
    .A(A),
    .B(B),
    .C(C),
    .ChaveNegativaPositiva(ChaveNegativaPositiva),
    .MudarTime(MudarTime),
    .ZerarPlacar(ZerarPlacar),
    .Placar0(Placar0),
    .Placar1(Placar1),
    .PontoAplicado(PontoAplicado),
    .Busina(Busina)
  );

  // Clock and output activity counters, sampled on the falling edge.
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (PontoAplicado === 1'b1) pa_cnt <= pa_cnt + 1;
    if (Busina === 1'b1)        bz_cnt <= bz_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Event-level reference: one press moves one score by the button's worth.
  task automatic model_event(input logic [2:0] mask, input bit sub, input bit team,
                             output int epa, output int ebz);
    int pts, s, n;
    pts = mask[2] ? 3 : (mask[1] ? 2 : 1);
    s   = team ? m1 : m0;
    n   = s;
    ebz = 0;
    if (!sub) begin
      n = s + pts;
      if (n > MAXP) begin
        n   = MAXP;
        ebz = 1;
      end
    end else if (pts > s) begin
      ebz = 1;
    end else begin
      n = s - pts;
    end
    epa = (n != s) ? 1 : 0;
    if (team) m1 = n;
    else      m0 = n;
  endtask

  task automatic drive_press(input logic [2:0] mask, input int hold, input bit sub, input bit team);
    ChaveNegativaPositiva = sub;
    MudarTime             = team;
    {C, B, A}             = mask;
    repeat (hold) tick();
    {C, B, A} = 3'b000;
    repeat (DEB + 12) tick();
  endtask

  task automatic do_press(input string tag, input logic [2:0] mask, input int hold,
                          input bit sub, input bit team);
    int pa0, bz0, epa, ebz;
    pa0 = pa_cnt;
    bz0 = bz_cnt;
    drive_press(mask, hold, sub, team);
    if (hold >= DEB) begin
      model_event(mask, sub, team, epa, ebz);
    end else begin
      epa = 0;
      ebz = 0;
    end
    check({tag, "_p0"}, int'(Placar0), m0);
    check({tag, "_p1"}, int'(Placar1), m1);
    check({tag, "_pa"}, pa_cnt - pa0, epa);
    check({tag, "_bz"}, bz_cnt - bz0, ebz * BUZZ);
  endtask

  task automatic climb(input bit team, input int target);
    int diff;
    logic [2:0] mask;
    while ((team ? m1 : m0) < target) begin
      diff = target - (team ? m1 : m0);
      mask = (diff >= 3) ? 3'b100 : ((diff == 2) ? 3'b010 : 3'b001);
      do_press($sformatf("climb_t%0d", team), mask, 10, 1'b0, team);
    end
  endtask

  initial begin
    int pa0, bz0, epa, ebz;

    vecs[0]  = '{3'b010, 20, 1'b0, 1'b0, 2, 0, 1, 0};
    vecs[1]  = '{3'b100, 20, 1'b0, 1'b1, 2, 3, 1, 0};
    vecs[2]  = '{3'b010, 20, 1'b0, 1'b1, 2, 5, 1, 0};
    vecs[3]  = '{3'b100, 20, 1'b1, 1'b1, 2, 2, 1, 0};
    vecs[4]  = '{3'b100, 20, 1'b1, 1'b1, 2, 2, 0, 1};
    vecs[5]  = '{3'b101, 30, 1'b0, 1'b0, 5, 2, 1, 0};
    vecs[6]  = '{3'b010,  2, 1'b0, 1'b0, 5, 2, 0, 0};
    vecs[7]  = '{3'b010,  3, 1'b0, 1'b0, 5, 2, 0, 0};
    vecs[8]  = '{3'b010,  4, 1'b0, 1'b0, 7, 2, 1, 0};
    vecs[9]  = '{3'b011, 20, 1'b1, 1'b0, 5, 2, 1, 0};
    vecs[10] = '{3'b111, 20, 1'b1, 1'b1, 5, 2, 0, 1};
    vecs[11] = '{3'b010, 20, 1'b1, 1'b1, 5, 0, 1, 0};

    reset = 1'b1;
    {C, B, A} = 3'b000;
    ChaveNegativaPositiva = 1'b0;
    MudarTime = 1'b0;
    ZerarPlacar = 1'b0;
    repeat (3) tick();
    check("rst_p0", int'(Placar0), 0);
    check("rst_p1", int'(Placar1), 0);
    check("rst_pa", int'(PontoAplicado), 0);
    check("rst_bz", int'(Busina), 0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 12; i++) begin
      pa0 = pa_cnt;
      bz0 = bz_cnt;
      drive_press(vecs[i].mask, vecs[i].hold, vecs[i].sub, vecs[i].team);
      check($sformatf("vec%0d_p0", i), int'(Placar0), vecs[i].e0);
      check($sformatf("vec%0d_p1", i), int'(Placar1), vecs[i].e1);
      check($sformatf("vec%0d_pa", i), pa_cnt - pa0, vecs[i].epa);
      check($sformatf("vec%0d_bz", i), bz_cnt - bz0, vecs[i].ebz * BUZZ);
      m0 = vecs[i].e0;
      m1 = vecs[i].e1;
    end

    // Exact latency: update and pulse appear DEB+4 edges after the press edge.
    ChaveNegativaPositiva = 1'b0;
    MudarTime = 1'b0;
    A = 1'b1;
    repeat (DEB + 3) tick();
    check("lat_before_p0", int'(Placar0), m0);
    check("lat_before_pa", int'(PontoAplicado), 0);
    tick();
    check("lat_at_p0", int'(Placar0), m0 + 1);
    check("lat_at_pa", int'(PontoAplicado), 1);
    tick();
    check("lat_after_pa", int'(PontoAplicado), 0);
    A = 1'b0;
    repeat (DEB + 12) tick();
    m0 = m0 + 1;

    climb(1'b0, 97);
    do_press("sat_c", 3'b100, 12, 1'b0, 1'b0);
    check("sat_c_val", int'(Placar0), 99);
    do_press("sat_a", 3'b001, 12, 1'b0, 1'b0);
    check("sat_a_val", int'(Placar0), 99);

    // Second button pressed while the first is still held is ignored.
    pa0 = pa_cnt;
    ChaveNegativaPositiva = 1'b0;
    MudarTime = 1'b1;
    A = 1'b1;
    repeat (20) tick();
    B = 1'b1;
    repeat (20) tick();
    A = 1'b0;
    B = 1'b0;
    repeat (DEB + 12) tick();
    model_event(3'b001, 1'b0, 1'b1, epa, ebz);
    check("repress_p0", int'(Placar0), m0);
    check("repress_p1", int'(Placar1), m1);
    check("repress_pa", pa_cnt - pa0, 1);

    // Team switch flipped right after capture does not redirect the point.
    pa0 = pa_cnt;
    ChaveNegativaPositiva = 1'b1;
    MudarTime = 1'b0;
    A = 1'b1;
    repeat (DEB + 3) tick();
    MudarTime = 1'b1;
    repeat (15) tick();
    A = 1'b0;
    repeat (DEB + 12) tick();
    model_event(3'b001, 1'b1, 1'b0, epa, ebz);
    check("mudar_p0", int'(Placar0), m0);
    check("mudar_p1", int'(Placar1), m1);
    check("mudar_pa", pa_cnt - pa0, 1);

    ZerarPlacar = 1'b1;
    tick();
    ZerarPlacar = 1'b0;
    m0 = 0;
    m1 = 0;
    check("zerar_p0", int'(Placar0), 0);
    check("zerar_p1", int'(Placar1), 0);

    climb(1'b0, 10);
    climb(1'b1, 20);

    // Clear asserted exactly in the APPLY cycle of a +2.
    pa0 = pa_cnt;
    ChaveNegativaPositiva = 1'b0;
    MudarTime = 1'b0;
    B = 1'b1;
    repeat (DEB + 3) tick();
    ZerarPlacar = 1'b1;
    tick();
    ZerarPlacar = 1'b0;
    check("zapply_p0", int'(Placar0), 0);
    check("zapply_p1", int'(Placar1), 0);
    check("zapply_pa_now", int'(PontoAplicado), 0);
    repeat (10) tick();
    B = 1'b0;
    repeat (DEB + 12) tick();
    check("zapply_pa_cnt", pa_cnt - pa0, 0);
    check("zapply_p0_end", int'(Placar0), 0);
    m0 = 0;
    m1 = 0;

    // Reset while buzzing, with A held across reset.
    ChaveNegativaPositiva = 1'b1;
    MudarTime = 1'b1;
    A = 1'b1;
    repeat (DEB + 4) tick();
    check("rbz_busina_on", int'(Busina), 1);
    ChaveNegativaPositiva = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rbz_p0", int'(Placar0), 0);
    check("rbz_p1", int'(Placar1), 0);
    check("rbz_pa", int'(PontoAplicado), 0);
    check("rbz_bz", int'(Busina), 0);
    pa0 = pa_cnt;
    repeat (DEB + 3) tick();
    check("rbz_held_early", int'(Placar1), 0);
    tick();
    check("rbz_held_p1", int'(Placar1), 1);
    check("rbz_held_pa", int'(PontoAplicado), 1);
    A = 1'b0;
    repeat (DEB + 12) tick();
    check("rbz_held_pa_cnt", pa_cnt - pa0, 1);
    m0 = 0;
    m1 = 1;

    for (int i = 0; i < 40; i++) begin
      logic [2:0] mask;
      int hold;
      mask = 3'($urandom_range(1, 7));
      if ($urandom_range(0, 4) == 0) hold = $urandom_range(1, DEB - 1);
      else                           hold = $urandom_range(DEB, 20);
      do_press($sformatf("rnd%0d", i), mask, hold, 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
